// File: rtl/memory_access.sv
// memory_access: MEM stage of the RV32 pipeline.
// Takes one execute result per ex_valid/ex_ready handshake. Loads and stores
// go out on a req/gnt/rvalid data bus with byte-lane steering and load
// sign/zero extension. Non-memory results pass through, registered, to the
// writeback port.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses instead of issuing them to the bus.
module memory_access #(
  parameter int TIMEOUT_CYCLES = 256  // 0 disables the bus timeout
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  reg_write_addr,
  input  logic [31:0] reg_write_data,
  input  logic        reg_write_enable,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [2:0]  load_sel,
  input  logic [1:0]  store_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_rd;
  logic             op_we;
  logic [2:0]       op_lsel;
  logic [1:0]       op_off;

  logic [1:0]       off;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;
  logic             timeout_hit;
  logic             is_mem;
  logic             accept;

  assign off         = mem_addr[1:0];
  assign is_mem      = mem_read_enable | mem_write_enable;
  assign accept      = ex_valid & ex_ready;
  // A zero timeout never fires; the counter then just free-runs harmlessly.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;

  // Halves must be 2-byte aligned and words 4-byte aligned; an undefined
  // size code decodes as a word, matching the lane logic below.
  always_comb begin
    misalign = 1'b0;
    if (mem_read_enable) begin
      case (load_sel)
        3'b000, 3'b011: misalign = 1'b0;
        3'b001, 3'b100: misalign = off[0];
        default:        misalign = (off != 2'b00);
      endcase
    end else if (mem_write_enable) begin
      case (store_sel)
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = off[0];
        default: misalign = (off != 2'b00);
      endcase
    end
  end
`endif

  // Store lane steering: replicate the data across lanes, enable only the target bytes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_data;
    case (store_sel)
      2'b00: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{mem_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {off[1], 1'b0};
        st_wdata = {2{mem_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = mem_data;
      end
    endcase
  end

  // Load extraction from the returned word using the captured offset and size.
  always_comb begin
    ld_byte = 8'(dmem_rdata >> {op_off, 3'b000});
    ld_half = 16'(dmem_rdata >> {op_off[1], 4'b0000});
    case (op_lsel)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_ext = {24'b0, ld_byte};
      3'b100:  ld_ext = {16'b0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // Stage FSM with registered bus and writeback outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      op_rd      <= '0;
      op_we      <= 1'b0;
      op_lsel    <= '0;
      op_off     <= '0;
      ex_ready   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
      trap_addr     <= '0;
`endif
    end else begin
      // Pulses default low; only the retiring branch raises them.
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ex_ready <= 1'b1;
          if (accept) begin
            op_rd   <= reg_write_addr;
            op_we   <= reg_write_enable && (reg_write_addr != 5'd0);
            op_lsel <= load_sel;
            op_off  <= off;
`ifdef MEM_MISALIGN_TRAP_EN
            if (is_mem && misalign) begin
              wb_valid      <= 1'b1;
              wb_rd         <= reg_write_addr;
              wb_data       <= '0;
              misalign_trap <= 1'b1;
              trap_addr     <= mem_addr;
            end else
`endif
            if (is_mem) begin
              // A load wins if both enables are set.
              state      <= REQ;
              ex_ready   <= 1'b0;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= ~mem_read_enable;
              dmem_addr  <= {mem_addr[31:2], 2'b00};
              dmem_be    <= mem_read_enable ? 4'b1111 : st_be;
              dmem_wdata <= mem_read_enable ? 32'd0 : st_wdata;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= reg_write_enable && (reg_write_addr != 5'd0);
              wb_rd    <= reg_write_addr;
              wb_data  <= reg_write_data;
            end
          end
        end
        REQ: begin
          // A grant on the timeout cycle still completes the access.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            cnt      <= '0;
            if (dmem_we) begin
              state    <= IDLE;
              ex_ready <= 1'b1;
              wb_valid <= 1'b1;
              wb_rd    <= op_rd;
              wb_data  <= '0;
            end else begin
              state <= WAIT_R;
            end
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
            ex_ready <= 1'b1;
            wb_valid <= 1'b1;
            wb_rd    <= op_rd;
            wb_data  <= '0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            state    <= IDLE;
            ex_ready <= 1'b1;
            wb_valid <= 1'b1;
            wb_we    <= op_we;
            wb_rd    <= op_rd;
            wb_data  <= ld_ext;
          end else if (timeout_hit) begin
            state    <= IDLE;
            ex_ready <= 1'b1;
            wb_valid <= 1'b1;
            wb_rd    <= op_rd;
            wb_data  <= '0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
